// File: rtl/fm_pkg.sv
// fm_pkg: shared symbol type, complement helper and default sizes.
// Used by fm_frag_buffer and fm_frag_extract.
package fm_pkg;

   localparam int FM_BUFFER_COUNT = 2;
   localparam int FM_DEPTH        = 32;
   localparam int FM_DATA_BITS    = 2;
   localparam int FM_FRAG_SYMS    = 8;

   typedef logic [FM_DATA_BITS-1:0] fm_sym_t;

   // Base complement of a default-width symbol (A<->T, C<->G).
   function automatic fm_sym_t fm_comp(input fm_sym_t s);
      return ~s;
   endfunction

endpackage

// File: rtl/fm_frag_extract.sv
// fm_frag_extract: combinational window/pad of one symbol buffer.
// Optional reverse-complement orientation selected by rc_i.
module fm_frag_extract
   import fm_pkg::*;
#(
   parameter int DEPTH      = FM_DEPTH,
   parameter int DATA_BITS  = FM_DATA_BITS,
   parameter int FRAG_SYMS  = FM_FRAG_SYMS,
   localparam int ADDR_BITS = $clog2(DEPTH),
   localparam int IDX_BITS  = ADDR_BITS + 1,
   localparam int FRAG_LEN  = FRAG_SYMS * DATA_BITS
) (
   input  logic [DEPTH*DATA_BITS-1:0] buf_i,
   input  logic signed [IDX_BITS-1:0] idx_i,
   input  logic                       rc_i,
   output logic [FRAG_LEN-1:0]        frag_o
);

   localparam int POS_BITS = IDX_BITS + 1;

   logic signed [POS_BITS-1:0] pos [FRAG_SYMS];
   logic [ADDR_BITS-1:0]       addr [FRAG_SYMS];
   logic [DATA_BITS-1:0]       sym [FRAG_SYMS];
   logic [FRAG_SYMS-1:0]       hit;

   // Gather the window; positions outside the buffer read as zero.
   always_comb begin
      for (int k = 0; k < FRAG_SYMS; k++) begin
         pos[k]  = POS_BITS'(idx_i) + POS_BITS'(k);
         hit[k]  = !pos[k][POS_BITS-1] &&
                   (pos[k] < POS_BITS'(DEPTH));
         addr[k] = pos[k][ADDR_BITS-1:0];
         sym[k]  = '0;
         if (hit[k]) begin
            sym[k] = buf_i[addr[k]*DATA_BITS +: DATA_BITS];
         end
      end
   end

   // Place symbols; reverse mode flips order and complements real data only.
   always_comb begin
      frag_o = '0;
      for (int j = 0; j < FRAG_SYMS; j++) begin
         if (rc_i) begin
            if (hit[FRAG_SYMS-1-j]) begin
               frag_o[j*DATA_BITS +: DATA_BITS] = ~sym[FRAG_SYMS-1-j];
            end
         end else begin
            frag_o[j*DATA_BITS +: DATA_BITS] = sym[j];
         end
      end
   end

endmodule

// File: rtl/fm_frag_buffer.sv
// fm_frag_buffer: rotating symbol buffers with windowed fragment reads.
// Define FM_FRAG_REVCOMP_EN to add rc_mode (reverse-complement reads).
module fm_frag_buffer
   import fm_pkg::*;
#(
   parameter int BUFFER_COUNT = FM_BUFFER_COUNT,
   parameter int DEPTH        = FM_DEPTH,
   parameter int DATA_BITS    = FM_DATA_BITS,
   parameter int FRAG_SYMS    = FM_FRAG_SYMS,
   localparam int ADDR_BITS   = $clog2(DEPTH),
   localparam int IDX_BITS    = ADDR_BITS + 1,
   localparam int FRAG_LEN    = FRAG_SYMS * DATA_BITS
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_BITS-1:0]       in_wdata,
   input  logic                       chg_idx,
   input  logic                       frag_valid,
   output logic                       frag_ready,
   input  logic signed [IDX_BITS-1:0] frag_idx,
`ifdef FM_FRAG_REVCOMP_EN
   input  logic                       rc_mode,
`endif
   output logic                       out_valid,
   output logic [FRAG_LEN-1:0]        out_rdata,
   output logic                       out_wait
);

   localparam int SEL_BITS = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1;
   localparam logic [SEL_BITS-1:0]  SEL_LAST  = SEL_BITS'(BUFFER_COUNT-1);
   localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(DEPTH-1);

   logic [DATA_BITS-1:0] mem_q [BUFFER_COUNT][DEPTH];

   logic [BUFFER_COUNT-1:0] filled_q, filled_d;
   logic [SEL_BITS-1:0]     wr_sel_q, wr_sel_d;
   logic [SEL_BITS-1:0]     rd_sel_q, rd_sel_d;
   logic [ADDR_BITS-1:0]    waddr_q, waddr_d;
   logic                    out_valid_q, out_valid_d;
   logic [FRAG_LEN-1:0]     out_rdata_q, out_rdata_d;

   logic                       wr_fire, fill_done, rel_fire, rd_fire;
   logic                       rc;
   logic [DEPTH*DATA_BITS-1:0] rd_buf;
   logic [FRAG_LEN-1:0]        frag;

   function automatic logic [SEL_BITS-1:0] next_sel(
      input logic [SEL_BITS-1:0] s
   );
      return (s == SEL_LAST) ? '0 : s + 1'b1;
   endfunction

`ifdef FM_FRAG_REVCOMP_EN
   assign rc = rc_mode;
`else
   assign rc = 1'b0;
`endif

   assign in_ready   = ~filled_q[wr_sel_q];
   assign frag_ready = filled_q[rd_sel_q];
   assign out_wait   = ~in_ready;
   assign out_valid  = out_valid_q;
   assign out_rdata  = out_rdata_q;

   assign wr_fire   = in_valid && in_ready;
   assign fill_done = wr_fire && (waddr_q == ADDR_LAST);
   assign rel_fire  = chg_idx && frag_ready;
   assign rd_fire   = frag_valid && frag_ready;

   // Flatten the buffer being read (selection at request time).
   always_comb begin
      rd_buf = '0;
      for (int a = 0; a < DEPTH; a++) begin
         rd_buf[a*DATA_BITS +: DATA_BITS] = mem_q[rd_sel_q][a];
      end
   end

   fm_frag_extract #(
      .DEPTH     (DEPTH),
      .DATA_BITS (DATA_BITS),
      .FRAG_SYMS (FRAG_SYMS)
   ) u_extract (
      .buf_i  (rd_buf),
      .idx_i  (frag_idx),
      .rc_i   (rc),
      .frag_o (frag)
   );

   // Next-state for fill/release bookkeeping and the output register.
   always_comb begin
      filled_d    = filled_q;
      wr_sel_d    = wr_sel_q;
      rd_sel_d    = rd_sel_q;
      waddr_d     = waddr_q;
      out_valid_d = rd_fire;
      out_rdata_d = out_rdata_q;
      if (wr_fire) begin
         waddr_d = waddr_q + 1'b1;
      end
      if (fill_done) begin
         filled_d[wr_sel_q] = 1'b1;
         waddr_d            = '0;
         wr_sel_d           = next_sel(wr_sel_q);
      end
      if (rel_fire) begin
         filled_d[rd_sel_q] = 1'b0;
         rd_sel_d           = next_sel(rd_sel_q);
      end
      if (rd_fire) begin
         out_rdata_d = frag;
      end
   end

   // Control state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         filled_q    <= '0;
         wr_sel_q    <= '0;
         rd_sel_q    <= '0;
         waddr_q     <= '0;
         out_valid_q <= 1'b0;
         out_rdata_q <= '0;
      end else begin
         filled_q    <= filled_d;
         wr_sel_q    <= wr_sel_d;
         rd_sel_q    <= rd_sel_d;
         waddr_q     <= waddr_d;
         out_valid_q <= out_valid_d;
         out_rdata_q <= out_rdata_d;
      end
   end

   // Symbol storage; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem_q[wr_sel_q][waddr_q] <= in_wdata;
      end
   end

endmodule
